cache_axi_bridge: RTL and testbench

- Line-refill/writeback responder for the MEM-stage data cache.
- Accepts one 8-word cache-line read or write request from the cache and executes it as a single AXI4 INCR burst: 8 beats, 32-bit, 4 B/beat.
- Returns a one-cycle grant to the cache when the line transfer is complete.
- Sits between the cache's `axi_*` request port and the top-level AXI master.

---
 rtl/cache_axi_pkg.sv | 22 ++
 rtl/cache_axi_bridge_line_buf.sv | 44 ++++
 rtl/cache_axi_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared types and AXI burst constants for the data-cache
// line refill/writeback bridge (cache_axi_bridge, cache_line_buf).
package cache_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_DONE
  } state_e;

  localparam int unsigned LINE_WORDS = 8;
  localparam logic [7:0]  BURST_LEN  = 8'd7;
  localparam logic [2:0]  BURST_SIZE = 3'd2;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [2:0]  LAST_BEAT  = 3'd7;

endpackage

// File: rtl/cache_axi_bridge_line_buf.sv
// cache_line_buf: 8 x 32-bit cache-line buffer.
// Ports:
//   clk, rst         clock, asynchronous active-high clear
//   we, idx, wdata   single-word synchronous write
//   load, load_data  full-line parallel load (takes priority over we)
//   rd_data          parallel read of all words
module cache_line_buf
  import cache_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  idx,
  input  logic [31:0] wdata,
  input  logic        load,
  input  logic [31:0] load_data [0:LINE_WORDS-1],
  output logic [31:0] rd_data   [0:LINE_WORDS-1]
);

  logic [31:0] mem_q [0:LINE_WORDS-1];
  logic [31:0] mem_d [0:LINE_WORDS-1];

  always_comb begin
    mem_d = mem_q;
    if (load) begin
      mem_d = load_data;
    end else if (we) begin
      mem_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb rd_data = mem_q;

endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: executes one 8-word cache-line read (refill) or write
// (writeback) as a single AXI4 INCR burst (8 beats x 32 bit) and returns a
// one-cycle axi_gnt when the line transfer completes.
// Ports:
//   cache side : axi_addr, axi_rd_req, axi_rd_data[0:7], axi_wr_req,
//                axi_wr_data[0:7], axi_gnt, bus_err
//   AXI master : AR, R, AW, W, B channels
// Build option: CACHE_BRIDGE_POSTED_WRITE_EN grants a writeback right after
// the last W beat and collects the B response in the background.
// All AXI outputs decode from registered state; no input-to-output paths.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int unsigned          ID_W   = 4,
  parameter logic [ID_W-1:0]      AXI_ID = ID_W'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     axi_addr,
  input  logic            axi_rd_req,
  output logic [31:0]     axi_rd_data [0:7],
  input  logic            axi_wr_req,
  input  logic [31:0]     axi_wr_data [0:7],
  output logic            axi_gnt,
  output logic            bus_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  state_e      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        buf_we, buf_load;
  logic        accept_ok;

`ifdef CACHE_BRIDGE_POSTED_WRITE_EN
  logic b_pending_q, b_pending_d;
  logic post_err_q, post_err_d;
`endif

  cache_line_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .we        (buf_we),
    .idx       (beat_q),
    .wdata     (rdata),
    .load      (buf_load),
    .load_data (axi_wr_data),
    .rd_data   (axi_rd_data)
  );

`ifdef CACHE_BRIDGE_POSTED_WRITE_EN
  // Holding off new requests while B is outstanding keeps a refill from
  // overtaking the writeback it may depend on.
  assign accept_ok = !b_pending_q;
`else
  assign accept_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    err_d    = err_q;
    buf_we   = 1'b0;
    buf_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_ok && axi_wr_req) begin
          buf_load = 1'b1;
          addr_d   = axi_addr & ~32'h1F;
          beat_d   = '0;
          state_d  = S_WADDR;
        end else if (accept_ok && axi_rd_req) begin
          addr_d  = axi_addr & ~32'h1F;
          beat_d  = '0;
          state_d = S_RADDR;
        end
      end
      S_RADDR: if (arready) state_d = S_RDATA;
      S_RDATA: begin
        if (rvalid) begin
          buf_we = 1'b1;
          beat_d = beat_q + 3'd1;
          if ((rresp != RESP_OKAY) || (rlast != (beat_q == LAST_BEAT))) err_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_WADDR: if (awready) state_d = S_WDATA;
      S_WDATA: begin
        if (wready) begin
          beat_d = beat_q + 3'd1;
`ifdef CACHE_BRIDGE_POSTED_WRITE_EN
          if (beat_q == LAST_BEAT) state_d = S_DONE;
`else
          if (beat_q == LAST_BEAT) state_d = S_WRESP;
`endif
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          if (bresp != RESP_OKAY) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CACHE_BRIDGE_POSTED_WRITE_EN
  always_comb begin
    b_pending_d = b_pending_q;
    post_err_d  = 1'b0;
    if (state_q == S_WDATA && wready && beat_q == LAST_BEAT) begin
      b_pending_d = 1'b1;
    end else if (b_pending_q && bvalid) begin
      b_pending_d = 1'b0;
      post_err_d  = (bresp != RESP_OKAY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_pending_q <= 1'b0;
      post_err_q  <= 1'b0;
    end else begin
      b_pending_q <= b_pending_d;
      post_err_q  <= post_err_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    arid    = AXI_ID;
    araddr  = addr_q;
    arlen   = BURST_LEN;
    arsize  = BURST_SIZE;
    arburst = BURST_INCR;
    arvalid = (state_q == S_RADDR);
    rready  = (state_q == S_RDATA);
    awid    = AXI_ID;
    awaddr  = addr_q;
    awlen   = BURST_LEN;
    awsize  = BURST_SIZE;
    awburst = BURST_INCR;
    awvalid = (state_q == S_WADDR);
    wdata   = axi_rd_data[beat_q];
    wstrb   = 4'hF;
    wvalid  = (state_q == S_WDATA);
    wlast   = (state_q == S_WDATA) && (beat_q == LAST_BEAT);
    axi_gnt = (state_q == S_DONE);
`ifdef CACHE_BRIDGE_POSTED_WRITE_EN
    bready  = b_pending_q;
    bus_err = ((state_q == S_DONE) && err_q) || post_err_q;
`else
    bready  = (state_q == S_WRESP);
    bus_err = (state_q == S_DONE) && err_q;
`endif
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: refill, writeback (with W back-pressure),
// request priority, RRESP/BRESP/RLAST errors and mid-burst reset.
module tb_cache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] axi_addr;
  logic        axi_rd_req, axi_wr_req;
  logic [31:0] axi_rd_data [0:7];
  logic [31:0] axi_wr_data [0:7];
  logic        axi_gnt, bus_err;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;

  cache_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .axi_addr(axi_addr), .axi_rd_req(axi_rd_req),
    .axi_rd_data(axi_rd_data), .axi_wr_req(axi_wr_req), .axi_wr_data(axi_wr_data),
    .axi_gnt(axi_gnt), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait refill. err_beat gets SLVERR, rlast is driven on last_beat.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] base,
                         input int err_beat, input int last_beat, input logic exp_err);
    axi_addr = addr; axi_rd_req = 1'b1; arready = 1'b1;
    tick();
    check("rd_arvalid", {31'b0, arvalid}, 1);
    check("rd_araddr", araddr, addr & 32'hFFFF_FFE0);
    check("rd_arlen", {24'b0, arlen}, 7);
    check("rd_arsize_burst", {27'b0, arsize, arburst}, {27'b0, 3'd2, 2'b01});
    check("rd_no_aw", {31'b0, awvalid}, 0);
    tick();
    check("rd_rready", {31'b0, rready}, 1);
    check("rd_ar_dropped", {31'b0, arvalid}, 0);
    for (int b = 0; b < 8; b++) begin
      check("rd_no_early_gnt", {31'b0, axi_gnt}, 0);
      rvalid = 1'b1;
      rdata  = base + 32'(b);
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == last_beat);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    check("rd_gnt", {31'b0, axi_gnt}, 1);
    check("rd_bus_err", {31'b0, bus_err}, {31'b0, exp_err});
    check("rd_rready_off", {31'b0, rready}, 0);
    for (int i = 0; i < 8; i++) check("rd_word", axi_rd_data[i], base + 32'(i));
    tick();
    check("rd_gnt_one_cycle", {31'b0, axi_gnt}, 0);
    check("rd_err_one_cycle", {31'b0, bus_err}, 0);
    check("rd_no_reaccept", {31'b0, arvalid}, 0);
    axi_rd_req = 1'b0;
    tick();
    check("rd_idle", {31'b0, arvalid}, 0);
    check("rd_data_stable", axi_rd_data[7], base + 32'd7);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] base,
                          input logic toggle, input logic [1:0] resp,
                          input logic exp_err, input logic also_rd);
    int b;
    int it;
    for (int i = 0; i < 8; i++) axi_wr_data[i] = base + 32'(i);
    axi_addr = addr; axi_wr_req = 1'b1; axi_rd_req = also_rd;
    awready = 1'b1; wready = 1'b0;
    tick();
    check("wr_awvalid", {31'b0, awvalid}, 1);
    check("wr_awaddr", awaddr, addr & 32'hFFFF_FFE0);
    check("wr_awlen", {24'b0, awlen}, 7);
    check("wr_no_ar", {31'b0, arvalid}, 0);
    check("wr_no_w_before_aw", {31'b0, wvalid}, 0);
    tick();
    b = 0; it = 0;
    while (b < 8 && it < 40) begin
      wready = toggle ? ((it % 2) == 0) : 1'b1;
      check("wr_wvalid", {31'b0, wvalid}, 1);
      check("wr_wdata", wdata, base + 32'(b));
      check("wr_wlast", {31'b0, wlast}, (b == 7) ? 1 : 0);
      check("wr_wstrb", {28'b0, wstrb}, 32'hF);
      if (wready) b++;
      it++;
      tick();
    end
    wready = 1'b0;
    check("wr_all_beats", 32'(b), 8);
    check("wr_wvalid_off", {31'b0, wvalid}, 0);
`ifdef CACHE_BRIDGE_POSTED_WRITE_EN
    check("wr_post_gnt", {31'b0, axi_gnt}, 1);
    check("wr_post_err_at_gnt", {31'b0, bus_err}, 0);
    check("wr_post_bready", {31'b0, bready}, 1);
    tick();
    check("wr_post_blocked", {31'b0, awvalid | arvalid}, 0);
    axi_wr_req = 1'b0; axi_rd_req = 1'b0;
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check("wr_post_bus_err", {31'b0, bus_err}, {31'b0, exp_err});
    check("wr_post_bready_off", {31'b0, bready}, 0);
    tick();
    check("wr_post_err_one_cycle", {31'b0, bus_err}, 0);
`else
    check("wr_bready", {31'b0, bready}, 1);
    check("wr_no_gnt_before_b", {31'b0, axi_gnt}, 0);
    tick();
    check("wr_bready_hold", {31'b0, bready}, 1);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check("wr_gnt", {31'b0, axi_gnt}, 1);
    check("wr_bus_err", {31'b0, bus_err}, {31'b0, exp_err});
    tick();
    check("wr_gnt_one_cycle", {31'b0, axi_gnt}, 0);
    check("wr_no_reaccept", {31'b0, awvalid | arvalid}, 0);
    axi_wr_req = 1'b0; axi_rd_req = 1'b0;
    tick();
    check("wr_idle", {31'b0, awvalid | arvalid}, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    axi_addr = '0; axi_rd_req = 1'b0; axi_wr_req = 1'b0;
    for (int i = 0; i < 8; i++) axi_wr_data[i] = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) tick();
    check("rst_valids", {28'b0, arvalid, awvalid, wvalid, wlast}, 0);
    check("rst_readys", {30'b0, rready, bready}, 0);
    check("rst_gnt_err", {30'b0, axi_gnt, bus_err}, 0);
    check("rst_buf", axi_rd_data[3], 0);
    rst = 1'b0;
    tick();
    check("rst_arid", {28'b0, arid}, 1);

    do_read(32'h1000_0044, 32'hA0, -1, 7, 1'b0);
    do_write(32'h2000_0018, 32'hB0, 1'b1, 2'b00, 1'b0, 1'b0);
    do_write(32'h3000_0000, 32'hC0, 1'b0, 2'b00, 1'b0, 1'b1);
    check("both_buf_word2", axi_rd_data[2], 32'hC2);
    check("both_awid", {28'b0, awid}, 1);
    do_read(32'h4000_0020, 32'hD0, 3, 7, 1'b1);
    do_read(32'h4000_0040, 32'hE0, -1, 7, 1'b0);
    do_read(32'h5000_001F, 32'hF0, -1, 5, 1'b1);
    do_write(32'h6000_0000, 32'h60, 1'b0, 2'b10, 1'b1, 1'b0);

    // Reset while beat 4 of a refill is on the bus.
    axi_addr = 32'h7000_0000; axi_rd_req = 1'b1; arready = 1'b1;
    tick();
    tick();
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rdata = 32'h70 + 32'(b); rlast = 1'b0;
      tick();
    end
    rdata = 32'h74;
    #2 rst = 1'b1;
    #1;
    check("rstmid_rready", {31'b0, rready}, 0);
    check("rstmid_valids", {29'b0, arvalid, awvalid, wvalid}, 0);
    check("rstmid_buf", axi_rd_data[0], 0);
    rvalid = 1'b0; axi_rd_req = 1'b0;
    #1 rst = 1'b0;
    tick();
    check("rstmid_idle", {30'b0, rready, arvalid}, 0);
    do_read(32'h7000_0000, 32'h90, -1, 7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
